// File: rtl/run_ctrl_fsm_if.sv
// run_ctrl_fsm_if -- CPU-side bundle of the run controller.
//   cpu_en     controller -> CPU   clock-enable
//   cpu_ready  CPU -> controller   CPU consumes cpu_en this cycle
//   burst_len  host -> controller  accepted cycles per STEP command (0 acts as 1)
//   step_cnt   controller -> host  accepted-cycle counter
//   ovf        controller -> host  sticky step_cnt wrap flag
//   bp_valid   host -> controller  breakpoint enable
//   bp_cnt     host -> controller  breakpoint compare value
//   bp_hit     controller -> host  one-cycle breakpoint pulse
// modport master: the controller; modport slave: the CPU/host side.
interface run_ctrl_fsm_if #(
  parameter int STEP_W = 4
);
  logic              cpu_en;
  logic              cpu_ready;
  logic [STEP_W-1:0] burst_len;
  logic [STEP_W-1:0] step_cnt;
  logic              ovf;
  logic              bp_valid;
  logic [STEP_W-1:0] bp_cnt;
  logic              bp_hit;

  modport master (
    output cpu_en, step_cnt, ovf, bp_hit,
    input  cpu_ready, burst_len, bp_valid, bp_cnt
  );

  modport slave (
    input  cpu_en, step_cnt, ovf, bp_hit,
    output cpu_ready, burst_len, bp_valid, bp_cnt
  );
endinterface

// File: rtl/run_ctrl_fsm.sv
// run_ctrl_fsm -- push-button run/step/stop/clear controller for a CPU clock-enable.
// Ports:
//   clk, resetn                         clock, asynchronous active-low reset
//   btn_run/btn_step/btn_stop/btn_clr   raw asynchronous buttons (active high)
//   led_run, led_idle                   status LEDs (RUN or STEP / IDLE)
//   state                               IDLE=0, RUN=1, STEP=2, CLEAR=3
//   cpu                                 run_ctrl_fsm_if.master (cpu_en, cpu_ready,
//                                       burst_len, step_cnt, ovf, bp_valid, bp_cnt, bp_hit)
// Parameters: DB_CYCLES (debounce length, >=1), STEP_W (counter width, 1..16).
// Optional feature: define RUN_CTRL_BREAKPOINT_EN to stop RUN/STEP when step_cnt
// reaches bp_cnt; otherwise bp_valid/bp_cnt are ignored and bp_hit is 0.
module run_ctrl_fsm #(
  parameter int DB_CYCLES = 250000,
  parameter int STEP_W    = 4
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 btn_run,
  input  logic                 btn_step,
  input  logic                 btn_stop,
  input  logic                 btn_clr,
  output logic                 led_run,
  output logic                 led_idle,
  output logic [1:0]           state,
  run_ctrl_fsm_if.master       cpu
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STEP  = 2'd2,
    CLEAR = 2'd3
  } state_e;

  localparam int unsigned NB    = 4;  // button index: 0 run, 1 step, 2 stop, 3 clr
  localparam int          CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  // ---------------------------------------------------------------------------
  // Button conditioning: 2-flop sync, debounce, rising-edge command pulse
  // ---------------------------------------------------------------------------
  logic [NB-1:0]    btn_raw;
  logic [NB-1:0]    sync1_q, sync1_d;
  logic [NB-1:0]    sync2_q, sync2_d;
  logic [NB-1:0]    level_q, level_d;
  logic [NB-1:0]    armed_q, armed_d;
  logic [NB-1:0]    cmd_q, cmd_d;
  logic [CNT_W-1:0] db_cnt_q [NB];
  logic [CNT_W-1:0] db_cnt_d [NB];

  always_comb btn_raw = {btn_clr, btn_stop, btn_step, btn_run};

  // Synchronizers reset to 1 and a button is only armed once a released (0)
  // sample arrives, so a button held through reset never yields a command
  // until it is released and pressed again.
  always_comb begin
    sync1_d  = btn_raw;
    sync2_d  = sync1_q;
    level_d  = level_q;
    armed_d  = armed_q | ~sync2_q;
    cmd_d    = '0;
    db_cnt_d = db_cnt_q;
    for (int unsigned i = 0; i < NB; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != level_q[i]) begin
        if (db_cnt_q[i] == CNT_MAX) begin
          level_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + CNT_W'(1);
        end
      end
      // Registered from level_d so the pulse appears on the same edge the
      // debounced level rises.
      cmd_d[i] = armed_q[i] & level_d[i] & ~level_q[i];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_q  <= '1;
      sync2_q  <= '1;
      level_q  <= '0;
      armed_q  <= '0;
      cmd_q    <= '0;
      for (int unsigned i = 0; i < NB; i++) begin
        db_cnt_q[i] <= '0;
      end
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      level_q  <= level_d;
      armed_q  <= armed_d;
      cmd_q    <= cmd_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  // Priority clr > stop > run > step; losers in the same cycle are dropped.
  logic go_clr, go_stop, go_run, go_step;

  always_comb begin
    go_clr  = cmd_q[3];
    go_stop = cmd_q[2] & ~cmd_q[3];
    go_run  = cmd_q[0] & ~cmd_q[3] & ~cmd_q[2];
    go_step = cmd_q[1] & ~cmd_q[3] & ~cmd_q[2] & ~cmd_q[0];
  end

  // ---------------------------------------------------------------------------
  // Control FSM and counters
  // ---------------------------------------------------------------------------
  state_e            state_q, state_d;
  logic [STEP_W-1:0] burst_q, burst_d;
  logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
  logic              ovf_q, ovf_d;
  logic              cpu_en_w;
  logic              accept;
  logic              bp_event;

  always_comb begin
    cpu_en_w = (state_q == RUN) || ((state_q == STEP) && (burst_q != '0));
    accept   = cpu_en_w & cpu.cpu_ready;

    step_cnt_d = step_cnt_q;
    ovf_d      = ovf_q;
    if (accept) begin
      step_cnt_d = step_cnt_q + STEP_W'(1);
      if (&step_cnt_q) begin
        ovf_d = 1'b1;
      end
    end
  end

`ifdef RUN_CTRL_BREAKPOINT_EN
  logic bp_hit_q, bp_hit_d;

  // accept already implies RUN or STEP.
  always_comb begin
    bp_event = accept && cpu.bp_valid && (step_cnt_d == cpu.bp_cnt);
    bp_hit_d = bp_event;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bp_hit_q <= 1'b0;
    end else begin
      bp_hit_q <= bp_hit_d;
    end
  end

  always_comb cpu.bp_hit = bp_hit_q;
`else
  logic unused_bp;

  always_comb begin
    bp_event   = 1'b0;
    unused_bp  = ^{cpu.bp_valid, cpu.bp_cnt};
    cpu.bp_hit = 1'b0;
  end
`endif

  always_comb begin
    state_d = state_q;
    burst_d = burst_q;
    case (state_q)
      IDLE: begin
        if (go_clr) begin
          state_d = CLEAR;
        end else if (go_run) begin
          state_d = RUN;
        end else if (go_step) begin
          state_d = STEP;
          burst_d = (cpu.burst_len == '0) ? STEP_W'(1) : cpu.burst_len;
        end
      end
      RUN: begin
        if (go_clr) begin
          state_d = CLEAR;
        end else if (go_stop || bp_event) begin
          state_d = IDLE;
        end
      end
      STEP: begin
        if (accept) begin
          burst_d = burst_q - STEP_W'(1);
        end
        if (go_clr) begin
          state_d = CLEAR;
          burst_d = '0;
        end else if (go_stop || bp_event) begin
          state_d = IDLE;
          burst_d = '0;
        end else if (accept && (burst_q == STEP_W'(1))) begin
          state_d = IDLE;
        end
      end
      CLEAR: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // CLEAR overrides the counter update; cpu_en is 0 there so nothing is lost.
  logic [STEP_W-1:0] step_cnt_n;
  logic              ovf_n;

  always_comb begin
    step_cnt_n = step_cnt_d;
    ovf_n      = ovf_d;
    if (state_q == CLEAR) begin
      step_cnt_n = '0;
      ovf_n      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      burst_q    <= '0;
      step_cnt_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      burst_q    <= burst_d;
      step_cnt_q <= step_cnt_n;
      ovf_q      <= ovf_n;
    end
  end

  always_comb begin
    cpu.cpu_en   = cpu_en_w;
    cpu.step_cnt = step_cnt_q;
    cpu.ovf      = ovf_q;
    led_run      = (state_q == RUN) || (state_q == STEP);
    led_idle     = (state_q == IDLE);
    state        = state_q;
  end

endmodule

// File: tb/tb_run_ctrl_fsm.sv
// Directed bench for run_ctrl_fsm with DB_CYCLES=4, STEP_W=4.
// Raw button edge -> state change takes 2 + 4 + 1 = 7 clock edges.
module tb_run_ctrl_fsm;

`ifdef RUN_CTRL_BREAKPOINT_EN
  localparam bit BP_EN = 1'b1;
`else
  localparam bit BP_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       resetn;
  logic       btn_run, btn_step, btn_stop, btn_clr;
  logic       led_run, led_idle;
  logic [1:0] state;
  int         n_checks = 0;
  int         n_fail   = 0;

  run_ctrl_fsm_if #(.STEP_W(4)) bus ();

  run_ctrl_fsm #(.DB_CYCLES(4), .STEP_W(4)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .btn_run  (btn_run),
    .btn_step (btn_step),
    .btn_stop (btn_stop),
    .btn_clr  (btn_clr),
    .led_run  (led_run),
    .led_idle (led_idle),
    .state    (state),
    .cpu      (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance n rising edges and sample 1 ns later.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    btn_run = 0; btn_step = 0; btn_stop = 0; btn_clr = 0;
    bus.cpu_ready = 0; bus.burst_len = '0; bus.bp_valid = 0; bus.bp_cnt = '0;
    tick(2);
    n_checks++;
    if ({state, bus.cpu_en, led_run, led_idle, bus.step_cnt, bus.ovf, bus.bp_hit} !== {2'd0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_outputs: state=%0d cpu_en=%b led_run=%b led_idle=%b step_cnt=%0d ovf=%b bp_hit=%b, expected 0 0 0 1 0 0 0",
               state, bus.cpu_en, led_run, led_idle, bus.step_cnt, bus.ovf, bus.bp_hit);
    end
    @(negedge clk) resetn = 1'b1;
    tick(10);
    n_checks++;
    if (state !== 2'd0) begin n_fail++; $display("FAIL reset_idle: state=%0d expected 0", state); end
  endtask

  task automatic test_glitch();
    btn_run = 1;
    tick(2);
    btn_run = 0;
    for (int i = 0; i < 15; i++) begin
      tick(1);
      n_checks++;
      if ({state, bus.cpu_en} !== {2'd0, 1'b0}) begin
        n_fail++;
        $display("FAIL glitch_cycle%0d: state=%0d cpu_en=%b expected 0 0", i, state, bus.cpu_en);
      end
    end
  endtask

  task automatic test_run_latency();
    btn_run = 1;
    tick(6);
    n_checks++;
    if ({state, bus.cpu_en} !== {2'd0, 1'b0}) begin
      n_fail++; $display("FAIL run_before_7: state=%0d cpu_en=%b expected 0 0", state, bus.cpu_en);
    end
    tick(1);
    n_checks++;
    if ({state, bus.cpu_en, led_run, led_idle} !== {2'd1, 1'b1, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL run_at_7: state=%0d cpu_en=%b led_run=%b led_idle=%b expected 1 1 1 0", state, bus.cpu_en, led_run, led_idle);
    end
    tick(3);
    btn_run = 0;
    tick(10);
    bus.cpu_ready = 1;
    tick(20);
    bus.cpu_ready = 0;
    n_checks++;
    if ({bus.step_cnt, bus.ovf, state} !== {4'd4, 1'b1, 2'd1}) begin
      n_fail++;
      $display("FAIL run_wrap: step_cnt=%0d ovf=%b state=%0d expected 4 1 1", bus.step_cnt, bus.ovf, state);
    end
  endtask

  task automatic test_stop_run_same();
    btn_stop = 1; btn_run = 1;
    tick(6);
    n_checks++;
    if (state !== 2'd1) begin n_fail++; $display("FAIL stoprun_before: state=%0d expected 1", state); end
    tick(1);
    n_checks++;
    if ({state, bus.cpu_en} !== {2'd0, 1'b0}) begin
      n_fail++; $display("FAIL stoprun_idle: state=%0d cpu_en=%b expected 0 0", state, bus.cpu_en);
    end
    btn_stop = 0; btn_run = 0;
    tick(10);
  endtask

  task automatic test_clr_stop();
    btn_run = 1;
    tick(7);
    n_checks++;
    if (state !== 2'd1) begin n_fail++; $display("FAIL clrstop_run: state=%0d expected 1", state); end
    btn_run = 0;
    tick(10);
    btn_clr = 1; btn_stop = 1;
    tick(7);
    n_checks++;
    if ({state, bus.step_cnt, bus.ovf} !== {2'd3, 4'd4, 1'b1}) begin
      n_fail++; $display("FAIL clrstop_clear: state=%0d step_cnt=%0d ovf=%b expected 3 4 1", state, bus.step_cnt, bus.ovf);
    end
    tick(1);
    n_checks++;
    if ({state, bus.step_cnt, bus.ovf} !== {2'd0, 4'd0, 1'b0}) begin
      n_fail++; $display("FAIL clrstop_after: state=%0d step_cnt=%0d ovf=%b expected 0 0 0", state, bus.step_cnt, bus.ovf);
    end
    btn_clr = 0; btn_stop = 0;
    tick(10);
  endtask

  task automatic test_burst();
    logic [4:0] pat;
    int         exp_cnt [5];
    logic [1:0] exp_st  [5];
    pat     = 5'b10101;            // bit i applied in cycle i: 1,0,1,0,1
    exp_cnt = '{1, 1, 2, 2, 3};
    exp_st  = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd0};
    bus.burst_len = 4'd3;
    btn_step = 1;
    tick(7);
    n_checks++;
    if ({state, bus.cpu_en} !== {2'd2, 1'b1}) begin
      n_fail++; $display("FAIL burst_enter: state=%0d cpu_en=%b expected 2 1", state, bus.cpu_en);
    end
    for (int i = 0; i < 5; i++) begin
      bus.cpu_ready = pat[i];
      tick(1);
      n_checks++;
      if ({state, bus.step_cnt} !== {exp_st[i], 4'(exp_cnt[i])}) begin
        n_fail++;
        $display("FAIL burst_cycle%0d: state=%0d step_cnt=%0d expected %0d %0d", i, state, bus.step_cnt, exp_st[i], exp_cnt[i]);
      end
    end
    tick(3);
    n_checks++;
    if ({bus.step_cnt, bus.cpu_en} !== {4'd3, 1'b0}) begin
      n_fail++; $display("FAIL burst_done: step_cnt=%0d cpu_en=%b expected 3 0", bus.step_cnt, bus.cpu_en);
    end
    bus.cpu_ready = 0;
    btn_step = 0;
    tick(10);
  endtask

  task automatic test_burst_zero();
    bus.burst_len = 4'd0;
    btn_step = 1;
    tick(7);
    n_checks++;
    if ({state, bus.cpu_en} !== {2'd2, 1'b1}) begin
      n_fail++; $display("FAIL burst0_enter: state=%0d cpu_en=%b expected 2 1", state, bus.cpu_en);
    end
    bus.cpu_ready = 1;
    tick(1);
    n_checks++;
    if ({state, bus.step_cnt} !== {2'd0, 4'd4}) begin
      n_fail++; $display("FAIL burst0_one: state=%0d step_cnt=%0d expected 0 4", state, bus.step_cnt);
    end
    tick(3);
    n_checks++;
    if ({bus.step_cnt, bus.cpu_en} !== {4'd4, 1'b0}) begin
      n_fail++; $display("FAIL burst0_hold: step_cnt=%0d cpu_en=%b expected 4 0", bus.step_cnt, bus.cpu_en);
    end
    bus.cpu_ready = 0;
    btn_step = 0;
    tick(10);
  endtask

  task automatic test_breakpoint();
    int         exp_cnt;
    logic [1:0] exp_st;
    logic       exp_hit;
    btn_clr = 1;
    tick(8);
    btn_clr = 0;
    n_checks++;
    if (bus.step_cnt !== 4'd0) begin n_fail++; $display("FAIL bp_clear: step_cnt=%0d expected 0", bus.step_cnt); end
    tick(10);
    bus.bp_valid = 1; bus.bp_cnt = 4'd5;
    btn_run = 1;
    tick(7);
    btn_run = 0;
    n_checks++;
    if (state !== 2'd1) begin n_fail++; $display("FAIL bp_run: state=%0d expected 1", state); end
    bus.cpu_ready = 1;
    for (int i = 1; i <= 8; i++) begin
      tick(1);
      exp_cnt = (BP_EN && i > 5) ? 5 : i;
      exp_st  = (BP_EN && i >= 5) ? 2'd0 : 2'd1;
      exp_hit = BP_EN && (i == 5);
      n_checks++;
      if ({state, bus.step_cnt, bus.bp_hit} !== {exp_st, 4'(exp_cnt), exp_hit}) begin
        n_fail++;
        $display("FAIL bp_cycle%0d: state=%0d step_cnt=%0d bp_hit=%b expected %0d %0d %b",
                 i, state, bus.step_cnt, bus.bp_hit, exp_st, exp_cnt, exp_hit);
      end
    end
    bus.cpu_ready = 0;
    bus.bp_valid = 0;
    btn_stop = 1;
    tick(7);
    n_checks++;
    if (state !== 2'd0) begin n_fail++; $display("FAIL bp_stop: state=%0d expected 0", state); end
    btn_stop = 0;
    tick(10);
  endtask

  task automatic test_reset_mid_burst();
    bus.burst_len = 4'd15;
    btn_step = 1;
    tick(7);
    n_checks++;
    if (state !== 2'd2) begin n_fail++; $display("FAIL rst_step_enter: state=%0d expected 2", state); end
    bus.cpu_ready = 1;
    tick(3);
    #3 resetn = 1'b0;
    #1;
    n_checks++;
    if ({state, bus.cpu_en, led_run, led_idle, bus.step_cnt, bus.ovf, bus.bp_hit} !== {2'd0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL rst_async: state=%0d cpu_en=%b led_run=%b led_idle=%b step_cnt=%0d ovf=%b bp_hit=%b, expected 0 0 0 1 0 0 0",
               state, bus.cpu_en, led_run, led_idle, bus.step_cnt, bus.ovf, bus.bp_hit);
    end
    bus.cpu_ready = 0;
    tick(2);
    @(negedge clk) resetn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      n_checks++;
      if ({state, bus.cpu_en} !== {2'd0, 1'b0}) begin
        n_fail++; $display("FAIL rst_held_cycle%0d: state=%0d cpu_en=%b expected 0 0", i, state, bus.cpu_en);
      end
    end
    btn_step = 0;
    tick(10);
    btn_step = 1;
    tick(6);
    n_checks++;
    if (state !== 2'd0) begin n_fail++; $display("FAIL rst_repress_before: state=%0d expected 0", state); end
    tick(1);
    n_checks++;
    if ({state, bus.cpu_en} !== {2'd2, 1'b1}) begin
      n_fail++; $display("FAIL rst_repress: state=%0d cpu_en=%b expected 2 1", state, bus.cpu_en);
    end
    btn_step = 0;
    tick(2);
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_run_latency();
    test_stop_run_same();
    test_clr_stop();
    test_burst();
    test_burst_zero();
    test_breakpoint();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
